// File: rtl/paddle_ctrl.sv
// Pong player paddle: synchronises and debounces two buttons against the game tick,
// steps the paddle on press and auto-repeats while held, and flags ball/paddle overlap.
module paddle_ctrl #(
  parameter int unsigned DEBOUNCE_TICKS = 8,
  parameter int unsigned REPEAT_TICKS   = 50,
  parameter int unsigned PADDLE_LEN     = 4,
  parameter int unsigned START_POS      = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [3:0] ball_y,
  output logic [3:0] pos,
  output logic       moved,
  output logic       hit
);

  localparam logic [7:0] DB_N    = 8'(DEBOUNCE_TICKS);
  localparam logic [7:0] REP_N   = 8'(REPEAT_TICKS);
  localparam logic [3:0] MAX_POS = 4'(16 - PADDLE_LEN);
  localparam logic [3:0] RST_POS = 4'(START_POS);
  localparam logic [4:0] LEN_M1  = 5'(PADDLE_LEN - 1);

  typedef enum logic [1:0] {IDLE, HELD_UP, HELD_DOWN} state_t;

  // Index 0 = up button, index 1 = down button.
  logic [1:0]      raw;
  logic [1:0]      s1_q, s2_q;
  logic [1:0]      deb_q, deb_d, deb_prev_q;
  logic [1:0][7:0] cnt_q, cnt_d;

  state_t     state_q, state_d;
  logic [7:0] rep_q, rep_d;
  logic [3:0] pos_q, pos_d;
  logic       moved_q, moved_d;
  logic       hit_q, hit_d;

  logic       up_deb, dn_deb, up_rise, dn_rise;
  logic       step_up, step_dn;
  logic [4:0] pos_ext, ball_ext;

  assign raw = {btn_down, btn_up};

  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < 2; i++) begin
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] + 8'd1 == DB_N) begin
          deb_d[i] = ~deb_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  assign up_deb  = deb_q[0];
  assign dn_deb  = deb_q[1];
  assign up_rise = deb_q[0] & ~deb_prev_q[0];
  assign dn_rise = deb_q[1] & ~deb_prev_q[1];

  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    pos_d   = pos_q;
    moved_d = 1'b0;
    step_up = 1'b0;
    step_dn = 1'b0;
    case (state_q)
      IDLE: begin
        if (up_rise && !dn_deb) begin
          step_up = 1'b1;
          state_d = HELD_UP;
          rep_d   = '0;
        end else if (dn_rise && !up_deb) begin
          step_dn = 1'b1;
          state_d = HELD_DOWN;
          rep_d   = '0;
        end
      end
      HELD_UP: begin
        if (!up_deb || dn_deb) begin
          state_d = IDLE;
          rep_d   = '0;
        end else if (tick) begin
          if (rep_q + 8'd1 == REP_N) begin
            step_up = 1'b1;
            rep_d   = '0;
          end else begin
            rep_d = rep_q + 8'd1;
          end
        end
      end
      HELD_DOWN: begin
        if (!dn_deb || up_deb) begin
          state_d = IDLE;
          rep_d   = '0;
        end else if (tick) begin
          if (rep_q + 8'd1 == REP_N) begin
            step_dn = 1'b1;
            rep_d   = '0;
          end else begin
            rep_d = rep_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        rep_d   = '0;
      end
    endcase
    // Saturating steps: a blocked step leaves pos alone and raises no moved pulse.
    if (step_up && pos_q != 4'd0) begin
      pos_d   = pos_q - 4'd1;
      moved_d = 1'b1;
    end
    if (step_dn && pos_q != MAX_POS) begin
      pos_d   = pos_q + 4'd1;
      moved_d = 1'b1;
    end
  end

  assign pos_ext  = {1'b0, pos_q};
  assign ball_ext = {1'b0, ball_y};
  assign hit_d    = (ball_ext >= pos_ext) && (ball_ext <= pos_ext + LEN_M1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cnt_q      <= '0;
      state_q    <= IDLE;
      rep_q      <= '0;
      pos_q      <= RST_POS;
      moved_q    <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      s1_q       <= raw;
      s2_q       <= s1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      rep_q      <= rep_d;
      pos_q      <= pos_d;
      moved_q    <= moved_d;
      hit_q      <= hit_d;
    end
  end

  assign pos   = pos_q;
  assign moved = moved_q;
  assign hit   = hit_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl: reset, press, debounce reject, repeat/clamp,
// both-button lockout, hit window sweeps and reset mid-hold.
module tb_paddle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       btn_up;
  logic       btn_down;
  logic [3:0] ball_y;
  logic [3:0] pos;
  logic       moved;
  logic       hit;

  int n_cmp = 0;
  int n_err = 0;
  int moved_cnt = 0;

  paddle_ctrl #(
    .DEBOUNCE_TICKS(8),
    .REPEAT_TICKS  (50),
    .PADDLE_LEN    (4),
    .START_POS     (6)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .btn_up  (btn_up),
    .btn_down(btn_down),
    .ball_y  (ball_y),
    .pos     (pos),
    .moved   (moved),
    .hit     (hit)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (moved === 1'b1) moved_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One game tick every 4 clocks; returns on a falling edge.
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic sweep(input int p, input string tag);
    for (int y = 0; y < 16; y++) begin
      @(negedge clk) ball_y = 4'(y);
      @(negedge clk) check(tag, hit, (y >= p && y <= p + 3) ? 1 : 0);
    end
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; btn_up = 1'b0; btn_down = 1'b0; ball_y = 4'd7;
    repeat (3) @(negedge clk);
    check("rst_pos", pos, 6);
    check("rst_moved", moved, 0);
    check("rst_hit", hit, 0);
    reset = 1'b1; ball_y = 4'd0;
    ticks(100);
    check("idle_pos", pos, 6);
    check("idle_moved_cnt", moved_cnt, 0);

    sweep(6, "hit_pos6");

    // Single press with edge-exact timing
    btn_down = 1'b1;
    settle();
    ticks(7);
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    check("press_pre", pos, 6);
    @(negedge clk);
    check("press_pos", pos, 7);
    check("press_moved", moved, 1);
    @(negedge clk);
    check("press_moved_end", moved, 0);
    btn_down = 1'b0;
    ticks(10);
    check("press_final", pos, 7);
    check("press_moved_cnt", moved_cnt, 1);

    // Short glitches never pass the debouncer
    for (int r = 0; r < 4; r++) begin
      btn_up = 1'b1; ticks(5);
      btn_up = 1'b0; ticks(5);
    end
    check("glitch_pos", pos, 7);
    check("glitch_moved_cnt", moved_cnt, 1);

    // Hold down: entry step, repeats every 50 ticks, clamp at 12
    btn_down = 1'b1;
    settle();
    ticks(8);   check("hold_entry", pos, 8);
    ticks(49);  check("hold_pre_rep", pos, 8);
    ticks(1);   check("hold_rep1", pos, 9);
    ticks(50);  check("hold_rep2", pos, 10);
    ticks(100); check("hold_rep4", pos, 12);
    ticks(192); check("hold_clamp", pos, 12);
    check("hold_moved_cnt", moved_cnt, 6);
    btn_down = 1'b0;
    ticks(10);

    sweep(12, "hit_pos12");

    // Both buttons: one up step, then lockout
    btn_up = 1'b1;
    settle();
    ticks(8);   check("both_up_step", pos, 11);
    ticks(20);
    btn_down = 1'b1;
    settle();
    ticks(10);  check("both_pressed", pos, 11);
    ticks(100); check("both_hold", pos, 11);
    btn_down = 1'b0;
    settle();
    ticks(60);  check("both_release_dn", pos, 11);
    check("both_moved_cnt", moved_cnt, 7);
    btn_up = 1'b0;
    ticks(10);
    btn_up = 1'b1;
    settle();
    ticks(8);   check("repress_up", pos, 10);
    ticks(500); check("up_to_top", pos, 0);
    ticks(50);  check("up_clamp", pos, 0);
    check("up_moved_cnt", moved_cnt, 18);
    btn_up = 1'b0;
    ticks(10);

    sweep(0, "hit_pos0");

    // Reset mid-hold, then re-debounce from scratch
    btn_down = 1'b1;
    settle();
    ticks(8);   check("mid_step", pos, 1);
    ticks(10);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    check("mid_rst_pos", pos, 6);
    check("mid_rst_moved", moved, 0);
    reset = 1'b1;
    ticks(8);   check("redeb_wait", pos, 6);
    ticks(1);   check("redeb_step", pos, 7);
    btn_down = 1'b0;
    ticks(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/paddle_ctrl.md
# paddle_ctrl

Player paddle controller for the pong game, upstream of the ball logic. Takes two raw push-buttons, synchronises and debounces them against the 1 kHz game tick, and moves a vertical paddle on the 16-row field with press-to-step and hold-to-repeat behaviour. It also reports a registered `hit` flag telling the ball logic whether a given ball row lies on the paddle.

## Interface
Parameters:
- `DEBOUNCE_TICKS`, 8: consecutive game ticks an input must hold a new level before it is accepted (1..255).
- `REPEAT_TICKS`, 50: game ticks between repeat steps while a button is held (1..255).
- `PADDLE_LEN`, 4: paddle height in rows (1..16).
- `START_POS`, 6: paddle top row after reset (0..16-PADDLE_LEN).

Ports:
- `clk` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-low; sampled on `clk` rising edge.
- `tick` in 1: one-`clk`-wide game-tick strobe (1 kHz).
- `btn_up` in 1: raw asynchronous button, high = pressed; moves the paddle toward row 0.
- `btn_down` in 1: raw asynchronous button, high = pressed; moves the paddle toward row 15.
- `ball_y` in 4: ball row to test against the paddle.
- `pos` out 4: paddle top row.
- `moved` out 1: one-`clk` pulse on every change of `pos`.
- `hit` out 1: registered; 1 when `pos <= ball_y <= pos+PADDLE_LEN-1`.

## Operation
- Reset (`reset`==0 at an edge): `pos`=START_POS, `moved`=0, `hit`=0. Synchroniser flops, debounced levels and all counters go to 0. FSM goes to IDLE. `tick` is ignored while in reset.
- Synchroniser: two flops per button, clocked every `clk`.
- Debounce, per button: an 8-bit counter that advances only on `tick` while the synchronised level differs from the debounced level. The counter clears whenever the two levels agree. When the counter would reach DEBOUNCE_TICKS, the debounced level flips and the counter clears.
- Movement FSM, driven by the debounced levels U and D:
  - IDLE: a rising edge of U with D=0 steps up and goes to HELD_UP. A rising edge of D with U=0 steps down and goes to HELD_DOWN.
  - HELD_UP / HELD_DOWN: an 8-bit repeat counter advances on `tick`. When it would reach REPEAT_TICKS, the FSM steps in the held direction and clears the counter.
  - Exit to IDLE with no step when the held button releases or the opposite button becomes debounced-pressed. Both pressed means no motion.
  - The repeat counter clears on every entry to a HELD state.
- Step arithmetic: saturating, never wrapping. Up: `pos` = max(pos-1, 0). Down: `pos` = min(pos+1, 16-PADDLE_LEN). A step blocked at a limit leaves `pos` unchanged and does not pulse `moved`.
- Hit: compare in 5-bit unsigned, `hit` <= (ball_y >= pos) && (ball_y <= pos+PADDLE_LEN-1). The compare uses the current registered `pos`.

## Timing
- Button to debounced level: 2 `clk` of synchroniser, then the DEBOUNCE_TICKS-th qualifying `tick`. The debounced level flips at the edge where that tick is sampled.
- Debounced edge to `pos` update: 1 `clk`. `moved` is high during the same cycle that the new `pos` is first visible.
- Repeat step: `pos` updates at the edge sampling the REPEAT_TICKS-th `tick` after HELD entry, then every REPEAT_TICKS ticks.
- `hit`: 1 `clk` after `ball_y` or `pos` changes.
- A glitch shorter than DEBOUNCE_TICKS ticks never changes the debounced level, `pos` or `moved`.
- If `reset` is asserted mid-hold, `pos` returns to START_POS on that edge. After release, a still-held button must re-debounce from 0 before any motion.
- `tick` coinciding with a debounced edge: the entry step happens, the repeat counter clears, and that tick is not counted.

## Test plan
- Reset: hold `reset`=0 for 3 `clk` -> `pos`=6, `moved`=0, `hit`=0. Release with no buttons for 100 ticks -> `pos` stays 6.
- Single press: `btn_down`=1 for 10 ticks, then release -> `pos` goes 6->7 exactly once, 1 `clk` after the 8th tick. `moved` is high for exactly 1 `clk`.
- Debounce reject: `btn_up` pulsed high for 5 ticks, repeated 4 times with 5-tick gaps -> `pos` stays 6 and `moved` never asserts.
- Hold and clamp: `btn_down` held 400 ticks -> `pos` 7 at debounce, 8 at +50 ticks, ... reaches 12 and stays there. No `moved` pulses after 12.
- Both buttons: `btn_up` held, then `btn_down` pressed after 20 ticks -> one up-step only, no further motion while both are held. Releasing `btn_down` does not start a new step until `btn_up` is re-pressed.
- Hit window: with `pos`=6, sweep `ball_y` 0..15 -> `hit`=1 only for 6..9, each result 1 `clk` after `ball_y` is applied. Repeat at `pos`=0 (rows 0..3) and `pos`=12 (rows 12..15).
